// File: rtl/counter_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : counter_scheduler_if
// Description : Client-facing bundle of the shared interval counter scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface counter_scheduler_if #(
    parameter int SIZE       = 5,
    parameter int REQUESTERS = 4
);
    logic [REQUESTERS-1:0]      req;
    logic [REQUESTERS*SIZE-1:0] duration;
    logic [REQUESTERS-1:0]      grant;
    logic                       busy;
    logic [SIZE-1:0]            count;
    logic [REQUESTERS-1:0]      done;

    modport master (
        output req, duration,
        input  grant, busy, count, done
    );

    modport slave (
        input  req, duration,
        output grant, busy, count, done
    );
endinterface
`default_nettype wire

// File: rtl/counter_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : counter_scheduler
// Description : Round-robin time-sharing of one interval counter among clients.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_scheduler #(
    parameter int SIZE       = 5,
    parameter int REQUESTERS = 4
) (
    input  wire logic           clock,
    input  wire logic           reset,
    counter_scheduler_if.slave  sched_bus
);
    localparam int PTR_W = $clog2(REQUESTERS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                r_state_q, w_state_d;
    logic [PTR_W-1:0]      r_ptr_q, w_ptr_d;
    logic [PTR_W-1:0]      r_owner_q, w_owner_d;
    logic [SIZE-1:0]       r_count_q, w_count_d;
    logic [SIZE-1:0]       r_limit_q, w_limit_d;
    logic [REQUESTERS-1:0] r_grant_q, w_grant_d;
    logic [REQUESTERS-1:0] r_done_q, w_done_d;
    logic                  r_busy_q, w_busy_d;

    logic [2*REQUESTERS-1:0] w_req_dbl;
    logic [REQUESTERS-1:0]   w_req_rot;
    logic                    w_found;
    logic [PTR_W-1:0]        w_offset;
    logic [PTR_W:0]          w_win_sum;
    logic [PTR_W-1:0]        w_win;
    logic [REQUESTERS-1:0]   w_win_onehot;
    logic [SIZE-1:0]         w_dur_win;
    logic [PTR_W-1:0]        w_ptr_after_owner;
    logic                    w_owner_req;

    // Rotate requests so bit k is client (ptr+k) mod REQUESTERS; lowest set bit wins.
    always_comb begin
        w_req_dbl = {sched_bus.req, sched_bus.req};
        w_req_rot = REQUESTERS'(w_req_dbl >> r_ptr_q);
        w_found   = 1'b0;
        w_offset  = '0;
        for (int k = REQUESTERS - 1; k >= 0; k--) begin
            if (w_req_rot[k]) begin
                w_found  = 1'b1;
                w_offset = PTR_W'(k);
            end
        end
        w_win_sum = {1'b0, r_ptr_q} + {1'b0, w_offset};
        if (w_win_sum >= (PTR_W+1)'(REQUESTERS)) begin
            w_win_sum = w_win_sum - (PTR_W+1)'(REQUESTERS);
        end
        w_win        = w_win_sum[PTR_W-1:0];
        w_win_onehot = '0;
        w_win_onehot[w_win] = 1'b1;
        w_dur_win = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            if (w_win == PTR_W'(i)) begin
                w_dur_win = sched_bus.duration[i*SIZE +: SIZE];
            end
        end
        w_ptr_after_owner = (r_owner_q == PTR_W'(REQUESTERS - 1)) ? '0 : r_owner_q + PTR_W'(1);
        // The grant register is a one-hot copy of the owner, so it masks the owner's request.
        w_owner_req = |(sched_bus.req & r_grant_q);
    end

    always_comb begin
        w_state_d = r_state_q;
        w_ptr_d   = r_ptr_q;
        w_owner_d = r_owner_q;
        w_count_d = r_count_q;
        w_limit_d = r_limit_q;
        w_grant_d = r_grant_q;
        w_done_d  = '0;
        w_busy_d  = r_busy_q;
        case (r_state_q)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_d = ST_RUN;
                    w_owner_d = w_win;
                    w_grant_d = w_win_onehot;
                    w_busy_d  = 1'b1;
                    w_count_d = '0;
                    w_limit_d = w_dur_win;
                end
            end
            ST_RUN: begin
                if (!w_owner_req) begin
                    w_state_d = ST_IDLE;
                    w_grant_d = '0;
                    w_busy_d  = 1'b0;
                    w_count_d = '0;
                    w_ptr_d   = w_ptr_after_owner;
                end else if (r_count_q == r_limit_q) begin
                    w_state_d = ST_DONE;
                    w_done_d  = r_grant_q;
                end else begin
                    w_count_d = r_count_q + SIZE'(1);
                end
            end
            ST_DONE: begin
                w_state_d = ST_IDLE;
                w_grant_d = '0;
                w_busy_d  = 1'b0;
                w_count_d = '0;
                w_ptr_d   = w_ptr_after_owner;
            end
            default: begin
                w_state_d = ST_IDLE;
                w_grant_d = '0;
                w_busy_d  = 1'b0;
                w_count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state_q <= ST_IDLE;
            r_ptr_q   <= '0;
            r_owner_q <= '0;
            r_count_q <= '0;
            r_limit_q <= '0;
            r_grant_q <= '0;
            r_done_q  <= '0;
            r_busy_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_ptr_q   <= w_ptr_d;
            r_owner_q <= w_owner_d;
            r_count_q <= w_count_d;
            r_limit_q <= w_limit_d;
            r_grant_q <= w_grant_d;
            r_done_q  <= w_done_d;
            r_busy_q  <= w_busy_d;
        end
    end

    assign sched_bus.grant = r_grant_q;
    assign sched_bus.busy  = r_busy_q;
    assign sched_bus.count = r_count_q;
    assign sched_bus.done  = r_done_q;

endmodule
`default_nettype wire

// File: tb/tb_counter_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_scheduler
// Description : Self-checking bench for counter_scheduler against an interval model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_scheduler;
    localparam int S = 5;
    localparam int R = 4;

    logic clk;
    logic rst;

    counter_scheduler_if #(.SIZE(S), .REQUESTERS(R)) bus ();

    counter_scheduler #(.SIZE(S), .REQUESTERS(R)) dut (
        .clock     (clk),
        .reset     (rst),
        .sched_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;

    // Interval model: an owner holds the counter for elapsed = 0..limit+1 cycles.
    int m_owner;
    int m_el;
    int m_limit;
    int m_ptr;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_el    = 0;
        m_limit = 0;
        m_ptr   = 0;
    endtask

    task automatic model_step();
        if (m_owner < 0) begin
            for (int k = 0; k < R; k++) begin
                int c;
                c = (m_ptr + k) % R;
                if (m_owner < 0 && bus.req[c]) begin
                    m_owner = c;
                    m_limit = int'(bus.duration[c*S +: S]);
                    m_el    = 0;
                end
            end
        end else if (m_el <= m_limit) begin
            if (!bus.req[m_owner]) begin
                m_ptr   = (m_owner + 1) % R;
                m_owner = -1;
            end else begin
                m_el++;
            end
        end else begin
            m_ptr   = (m_owner + 1) % R;
            m_owner = -1;
        end
    endtask

    function automatic logic [31:0] exp_grant();
        return (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
    endfunction

    function automatic logic [31:0] exp_count();
        if (m_owner < 0) return 32'd0;
        return (m_el < m_limit) ? 32'(m_el) : 32'(m_limit);
    endfunction

    function automatic logic [31:0] exp_done();
        return (m_owner >= 0 && m_el == m_limit + 1) ? (32'd1 << m_owner) : 32'd0;
    endfunction

    task automatic compare_all();
        check_eq("grant", 32'(bus.grant), exp_grant());
        check_eq("busy",  32'(bus.busy),  (m_owner >= 0) ? 32'd1 : 32'd0);
        check_eq("count", 32'(bus.count), exp_count());
        check_eq("done",  32'(bus.done),  exp_done());
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_dur(input int c, input int d);
        bus.duration[c*S +: S] = S'(d);
    endtask

    int grant_cycles;
    int done_cycles;
    int guard;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.req = '0;
        bus.duration = '0;
        model_reset();
        apply_reset();

        // Single client, duration 3.
        set_dur(0, 3);
        bus.req = 4'b0001;
        tick();
        check_eq("first_grant", 32'(bus.grant), 32'd1);
        for (int i = 0; i < 6; i++) tick();
        bus.req = '0;
        tick();
        tick();

        // Zero duration: two grant cycles, done in the second.
        apply_reset();
        set_dur(2, 0);
        bus.req = 4'b0100;
        grant_cycles = 0;
        done_cycles  = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.grant[2]) grant_cycles++;
            if (bus.done[2])  done_cycles++;
        end
        check_eq("zero_dur_grant_cycles", 32'(grant_cycles), 32'd2);
        check_eq("zero_dur_done_cycles",  32'(done_cycles),  32'd1);
        bus.req = '0;
        tick();

        // All clients requesting with duration 1: rotating 4-cycle period.
        apply_reset();
        for (int c = 0; c < R; c++) set_dur(c, 1);
        bus.req = 4'b1111;
        for (int i = 0; i < 20; i++) tick();
        bus.req = '0;
        tick();
        tick();

        // Abort of client 1 at count 2; client 2 takes over after one idle edge.
        apply_reset();
        set_dur(1, 10);
        set_dur(2, 2);
        bus.req = 4'b0110;
        tick();
        check_eq("abort_first_owner", 32'(bus.grant), 32'b0010);
        guard = 0;
        while (exp_count() != 32'd2 && guard < 40) begin
            tick();
            guard++;
        end
        check_eq("abort_reach_count2", (guard < 40) ? 32'd1 : 32'd0, 32'd1);
        bus.req = 4'b0100;
        tick();
        check_eq("abort_grant_low", 32'(bus.grant), 32'd0);
        check_eq("abort_no_done",   32'(bus.done),  32'd0);
        tick();
        check_eq("abort_next_owner", 32'(bus.grant), 32'b0100);
        bus.req = '0;
        tick();
        tick();

        // Maximum duration: count saturates at 31, grant lasts 33 cycles.
        apply_reset();
        set_dur(0, 31);
        bus.req = 4'b0001;
        grant_cycles = 0;
        for (int i = 0; i < 34; i++) begin
            tick();
            if (bus.grant[0]) grant_cycles++;
        end
        check_eq("max_dur_grant_cycles", 32'(grant_cycles), 32'd33);
        bus.req = '0;
        tick();

        // Asynchronous reset in the middle of client 2's interval.
        apply_reset();
        set_dur(2, 5);
        bus.req = 4'b0100;
        for (int i = 0; i < 3; i++) tick();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        rst = 1'b0;
        bus.req = 4'b1001;
        set_dur(0, 2);
        set_dur(3, 2);
        tick();
        check_eq("post_reset_ptr", 32'(bus.grant), 32'b0001);
        bus.req = '0;
        for (int i = 0; i < 5; i++) tick();

        // Randomized traffic, including duration changes while counting.
        for (int c = 0; c < R; c++) set_dur(c, int'($urandom_range(0, 6)));
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                int b;
                b = int'($urandom_range(0, R - 1));
                bus.req[b] = ~bus.req[b];
            end
            if ($urandom_range(0, 9) == 0) begin
                int c;
                c = int'($urandom_range(0, R - 1));
                set_dur(c, ($urandom_range(0, 19) == 0) ? 31 : int'($urandom_range(0, 6)));
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/counter_scheduler.md
# counter_scheduler

Time-shares one Size-bit interval counter between Requesters clients. Each client raises a request with a programmed duration. A round-robin arbiter grants the counter to one client at a time, which counts from 0 up to that duration. The owner gets a one-cycle completion pulse. The block sits between client logic and the shared counter datapath; count is exported so the Ruby-VPI bench and other logic can observe progress.

## Interface
- Size, 5, counter and duration width in bits
- Requesters, 4, number of clients (≥2)

- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- req  in  Requesters  per-client request level; bit i = client i
- duration  in  Requesters*Size  packed; client i at [i*Size +: Size]; terminal count for client i
- grant  out  Requesters  one-hot (or zero) current owner
- busy  out  1  high while any grant is high
- count  out  Size  elapsed count of current interval
- done  out  Requesters  one-cycle completion pulse to owner

## Operation
- Reset: one clock; reset is asynchronous and active-high. On reset: state=IDLE, grant=0, busy=0, count=0, done=0, round-robin pointer ptr=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - If any req bit is high at an edge, the winner is the first set bit searching ptr, ptr+1, … mod Requesters.
  - Winner i → grant[i]=1, busy=1, count=0, limit=duration[i] latched, state=RUN.
  - No req high → remain IDLE, outputs unchanged at 0.
- RUN, at each edge:
  - If req[owner]=0 → abort: state=IDLE, grant=0, busy=0, count=0, ptr=(owner+1) mod Requesters. No done pulse.
  - Else if count==limit → state=DONE, done[owner]=1; grant, busy and count held.
  - Else count=count+1.
- DONE, next edge: done=0, grant=0, busy=0, count=0, ptr=(owner+1) mod Requesters, state=IDLE. req[owner] is ignored in DONE.
- Abort check has priority over the terminal check when both apply in the same cycle.
- duration is sampled only at grant; later changes to it are ignored until the next grant.
- count never wraps: the maximum limit is 2^Size−1 and counting stops at limit.
- Non-owner req changes during RUN/DONE have no effect until IDLE.
- Reset asserted mid-interval: all outputs go to 0 without waiting for an edge; no done pulse is emitted.

## Timing
- Grant latency: req sampled high in IDLE → grant at next edge (1 cycle).
- Interval for duration D: grant high D+2 cycles. That is D+1 RUN cycles with count 0..D, then 1 DONE cycle with count=D and done high.
- Release to IDLE takes 1 edge; the earliest next grant is 1 edge later, giving a minimum 1-cycle gap with grant=0 between owners.
- Abort: grant falls at the first edge where req[owner]=0 is sampled in RUN.
- All outputs are registered; no combinational input-to-output paths.
- grant, busy, count and done change only on clock edges, except on reset assertion.

## Test plan
- Reset then req=0001, duration[0]=3:
  - Grant[0] rises edge 1.
  - Count reads 0,1,2,3 on edges 1-4.
  - Done[0]=1 only after edge 5, with count=3.
  - Grant[0] and busy fall at edge 6.
- req=0100, duration[2]=0:
  - Grant[2] is high for 2 cycles with count=0.
  - Done[2] pulses in the second cycle.
- req=1111 held, all durations=1, Size=5:
  - Grant sequence is 0001, 0010, 0100, 1000, 0001.
  - Each grant lasts 3 cycles, followed by 1 idle cycle, for a 4-cycle period.
  - Done pulses in the same order.
- req=0110, duration[1]=10; drop req[1] when count=2:
  - Grant[1] falls at the next edge with no done[1].
  - Count returns to 0.
  - Grant[2] rises at the following edge.
- req=0001, duration[0]=31 (Size=5):
  - Count climbs to 31 with no wrap to 0.
  - Done[0] is asserted with count=31.
  - Grant lasts 33 cycles.
- During RUN of client 2 (ptr would advance to 3), assert reset between edges:
  - Grant, busy, count and done are 0 immediately.
  - After release with req=1001, grant[0] wins, confirming ptr was reset to 0.
